// File: rtl/ror_arb.sv
// Two-requester round-robin arbiter sharing one 32-bit rotate-right unit.
// Latency: 1 cycle from grant to registered result.
// Backpressure: a held result with rsp_ready low blocks all grants; pass-through on rsp_ready keeps 1 result/cycle.
module ror_arb (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic [31:0] a_data,
    input  logic [4:0]  a_num,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [31:0] b_data,
    input  logic [4:0]  b_num,
    output logic        b_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_id,
    input  logic        rsp_ready,
    output logic [15:0] cnt_a,
    output logic [15:0] cnt_b
);

    // prio names the requester that wins a tie: 0 = A, 1 = B
    logic        prio;
    logic        slot_free;
    logic        grant_a;
    logic        grant_b;
    logic [31:0] sel_data;
    logic [4:0]  sel_num;
    logic [63:0] dbl_shift;
    logic [31:0] rot_data;

    // Grant decision: the slot must be free; a lone requester wins, a tie goes to prio.
    // Only valids, prio and slot state feed this path, never the operands.
    always_comb begin
        slot_free = !rsp_valid || rsp_ready;
        grant_a   = 1'b0;
        grant_b   = 1'b0;
        if (!rst && slot_free) begin
            if (a_valid && b_valid) begin
                grant_a = !prio;
                grant_b = prio;
            end else begin
                grant_a = a_valid;
                grant_b = b_valid;
            end
        end
        a_ready = grant_a;
        b_ready = grant_b;
    end

    // Shared rotator: shifting a doubled copy right leaves the rotated word in the low half,
    // which also covers num = 0 without a special case.
    always_comb begin
        sel_data  = grant_b ? b_data : a_data;
        sel_num   = grant_b ? b_num  : a_num;
        dbl_shift = {sel_data, sel_data} >> sel_num;
        rot_data  = dbl_shift[31:0];
    end

    // Result slot, round-robin pointer and per-requester acceptance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= 32'h0;
            rsp_id    <= 1'b0;
            prio      <= 1'b0;
            cnt_a     <= 16'h0;
            cnt_b     <= 16'h0;
        end else begin
            if (grant_a || grant_b) begin
                rsp_valid <= 1'b1;
                rsp_data  <= rot_data;
                rsp_id    <= grant_b;
                // point at whoever lost (or was absent) so it wins the next tie
                prio      <= grant_a;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            if (grant_a) begin
                cnt_a <= cnt_a + 16'd1;
            end
            if (grant_b) begin
                cnt_b <= cnt_b + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_ror_arb.sv
// Randomized and directed bench for ror_arb against a transaction-level reference.
// Latency: checks readies before each edge and the result slot 1 time unit after it.
// Backpressure: rsp_ready is randomized and forced low in a directed stall sequence.
module tb_ror_arb;

    logic        clk;
    logic        rst;
    logic        a_valid;
    logic [31:0] a_data;
    logic [4:0]  a_num;
    logic        a_ready;
    logic        b_valid;
    logic [31:0] b_data;
    logic [4:0]  b_num;
    logic        b_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_id;
    logic        rsp_ready;
    logic [15:0] cnt_a;
    logic [15:0] cnt_b;

    int n_cmp;
    int n_bad;

    // reference state kept as plain values
    bit          m_vld;
    logic [31:0] m_dat;
    bit          m_id;
    int          m_prio;
    int          m_ca;
    int          m_cb;

    // DUT readies observed in the most recent step
    logic s_ar;
    logic s_br;

    ror_arb dut (
        .clk       (clk),
        .rst       (rst),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_num     (a_num),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_num     (b_num),
        .b_ready   (b_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready),
        .cnt_a     (cnt_a),
        .cnt_b     (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // rotate right one bit at a time
    function automatic logic [31:0] ror_ref(input logic [31:0] d, input int n);
        logic [31:0] r;
        r = d;
        for (int k = 0; k < n; k++) r = {r[0], r[31:1]};
        return r;
    endfunction

    // One clock: predict and check readies, take the edge, advance the reference, check the slot.
    task automatic step();
        bit ga;
        bit gb;
        bit free;
        #1;
        free = !m_vld || rsp_ready;
        ga = 0;
        gb = 0;
        if (!rst && free) begin
            if (a_valid && b_valid) begin
                if (m_prio == 0) ga = 1; else gb = 1;
            end else if (a_valid) begin
                ga = 1;
            end else if (b_valid) begin
                gb = 1;
            end
        end
        s_ar = a_ready;
        s_br = b_ready;
        check("a_ready", a_ready, ga);
        check("b_ready", b_ready, gb);
        @(posedge clk);
        if (rst) begin
            m_vld = 0; m_dat = 32'h0; m_id = 0; m_prio = 0; m_ca = 0; m_cb = 0;
        end else if (ga || gb) begin
            m_vld  = 1;
            m_dat  = ga ? ror_ref(a_data, int'(a_num)) : ror_ref(b_data, int'(b_num));
            m_id   = gb;
            m_prio = ga ? 1 : 0;
            if (ga) m_ca = (m_ca + 1) % 65536;
            if (gb) m_cb = (m_cb + 1) % 65536;
        end else if (rsp_ready) begin
            m_vld = 0;
        end
        #1;
        check("rsp_valid", rsp_valid, m_vld);
        check("rsp_data", rsp_data, m_dat);
        check("rsp_id", rsp_id, m_id);
        check("cnt_a", cnt_a, m_ca);
        check("cnt_b", cnt_b, m_cb);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] e;
        n_cmp = 0; n_bad = 0;
        m_vld = 0; m_dat = 0; m_id = 0; m_prio = 0; m_ca = 0; m_cb = 0;
        rst = 1'b1; rsp_ready = 1'b1;
        a_valid = 0; a_data = 0; a_num = 0;
        b_valid = 0; b_data = 0; b_num = 0;
        step();

        // reset state and readies held low while in reset
        a_valid = 1; b_valid = 1;
        step();
        check("rst_a_ready", s_ar, 0);
        check("rst_b_ready", s_br, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 32'h0);
        check("rst_cnt_a", cnt_a, 0);
        rst = 0;

        // A only, single rotate
        do_reset();
        a_valid = 1; a_data = 32'h8000_0001; a_num = 1; rsp_ready = 1;
        step();
        check("single_a_ready", s_ar, 1);
        check("single_data", rsp_data, 32'hC000_0000);
        check("single_id", rsp_id, 0);
        check("single_cnt_a", cnt_a, 1);
        check("single_valid", rsp_valid, 1);

        // continuous contention alternates A, B starting with A
        do_reset();
        a_valid = 1; a_data = 32'h1234_5678; a_num = 4;
        b_valid = 1; b_data = 32'hDEAD_BEEF; b_num = 0;
        rsp_ready = 1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("alt_data", rsp_data, (i % 2 == 0) ? 32'h8123_4567 : 32'hDEAD_BEEF);
            check("alt_id", rsp_id, i % 2);
        end

        // backpressure: three stalled cycles, then the prio requester (A after a B grant) wins
        rsp_ready = 0;
        step();
        check("bp_first_id", rsp_id, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_a_ready", s_ar, 0);
            check("bp_b_ready", s_br, 0);
            check("bp_hold_data", rsp_data, 32'hDEAD_BEEF);
        end
        rsp_ready = 1;
        step();
        check("bp_release_a", s_ar, 1);
        check("bp_release_data", rsp_data, 32'h8123_4567);

        // rotate sweep of a single set bit
        do_reset();
        b_valid = 0; a_valid = 1; a_data = 32'h0000_0001; rsp_ready = 1;
        for (int n = 0; n < 32; n++) begin
            a_num = n[4:0];
            step();
            e = 32'h1 << ((32 - n) % 32);
            check("sweep", rsp_data, e);
        end

        // reset with a result pending and both requesters valid
        a_valid = 1; b_valid = 1; rsp_ready = 0;
        step();
        step();
        rst = 1;
        step();
        check("midrst_valid", rsp_valid, 0);
        check("midrst_cnt_a", cnt_a, 0);
        check("midrst_cnt_b", cnt_b, 0);
        rst = 0; rsp_ready = 0;
        step();
        check("midrst_first_a", s_ar, 1);
        check("midrst_first_b", s_br, 0);

        // randomized traffic with requesters holding operands until accepted
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rsp_ready = ($urandom_range(0, 9) < 7);
            rst = ($urandom_range(0, 199) == 0);
            if (!a_valid || s_ar) begin
                a_valid = $urandom_range(0, 1);
                a_data = $urandom;
                a_num = 5'($urandom_range(0, 31));
            end
            if (!b_valid || s_br) begin
                b_valid = $urandom_range(0, 1);
                b_data = $urandom;
                b_num = 5'($urandom_range(0, 31));
            end
            step();
        end
        rst = 0;

        // counter wrap after 65536 A grants
        do_reset();
        a_valid = 1; b_valid = 0; rsp_ready = 1; a_data = 32'h5; a_num = 3;
        for (int i = 0; i < 65536; i++) step();
        check("wrap_cnt_a", cnt_a, 0);
        check("wrap_cnt_b", cnt_b, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ror_arb.md
ROR_ARB -- requirements
Module: ror_arb

Interface
REQ-001: clk  input  1  single clock; all state updates on rising edge.
REQ-002: rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003: a_valid  input  1  requester A has an operation pending.
REQ-004: a_data  input  32  requester A operand.
REQ-005: a_num  input  5  requester A rotate-right amount, 0-31.
REQ-006: a_ready  output  1  requester A operation accepted this cycle (combinational).
REQ-007: b_valid, b_data, b_num, b_ready  same widths and meaning as the A ports, for requester B.
REQ-008: rsp_valid  output  1  result register holds an undelivered result.
REQ-009: rsp_data  output  32  rotated result.
REQ-010: rsp_id  output  1  owner of the result: 0 = A, 1 = B.
REQ-011: rsp_ready  input  1  consumer takes the result this cycle.
REQ-012: cnt_a, cnt_b  output  16  accepted-operation counters per requester.

Function
REQ-013: The block SHALL share one 32-bit rotate-right datapath between A and B: result = {data[num-1:0], data[31:num]} for num 1-31, data unchanged for num 0.
REQ-014: Result slot SHALL be a single register; slot_free = !rsp_valid || rsp_ready.
REQ-015: Grant SHALL occur only when slot_free = 1; at most one requester is granted per cycle; a_ready/b_ready SHALL be 0 when slot_free = 0.
REQ-016: If only one requester is valid and slot_free = 1, that requester SHALL be granted.
REQ-017: If both are valid and slot_free = 1, the requester named by priority pointer prio (0 = A, 1 = B) SHALL be granted.
REQ-018: After every grant, prio SHALL point to the non-granted requester (round-robin); prio SHALL not change on cycles without a grant.
REQ-019: On grant, the next rising edge SHALL load rsp_data with the rotated operand, rsp_id with the granted requester, and rsp_valid = 1 (latency 1 cycle).
REQ-020: If rsp_valid = 1 and rsp_ready = 1 with no grant, rsp_valid SHALL clear next cycle; with a grant the same cycle, the new result SHALL replace the old one with rsp_valid staying 1 (full throughput, one result per cycle).
REQ-021: If rsp_valid = 1 and rsp_ready = 0, rsp_data, rsp_id and rsp_valid SHALL hold unchanged.
REQ-022: a_ready/b_ready SHALL depend only on a_valid, b_valid, prio, rsp_valid, rsp_ready; data and num SHALL not affect them.
REQ-023: Requesters SHALL hold valid, data and num stable until ready; the block SHALL sample data/num only in the grant cycle.
REQ-024: cnt_a/cnt_b SHALL increment by 1 on each A/B grant, wrap 16'hFFFF -> 16'h0000, and never both increment in one cycle.
REQ-025: Under continuous contention with rsp_ready = 1, grants SHALL strictly alternate A, B, A, B...; neither requester waits more than one grant.

Reset
REQ-026: With rst = 1 at a rising edge: rsp_valid = 0, rsp_data = 32'h0, rsp_id = 0, prio = 0 (A first), cnt_a = cnt_b = 0.
REQ-027: While rst = 1, a_ready and b_ready SHALL be 0 and no grant SHALL occur.
REQ-028: Reset mid-operation SHALL discard any pending result; first cycle after reset release behaves as idle with slot_free = 1.

Verification
REQ-029: Reset, then A only: a_data=32'h8000_0001, a_num=1 -> a_ready=1 that cycle; next cycle rsp_valid=1, rsp_data=32'hC000_0000, rsp_id=0, cnt_a=1.
REQ-030: Both valid every cycle, rsp_ready=1, A num=4 data=32'h1234_5678, B num=0 data=32'hDEAD_BEEF -> results alternate 32'h8123_4567 (id 0), 32'hDEAD_BEEF (id 1), starting with A after reset.
REQ-031: Backpressure: result pending, rsp_ready=0 for 3 cycles with A and B valid -> a_ready=b_ready=0, rsp_data/rsp_id stable; on rsp_ready=1 the prio requester is granted and its result appears next cycle.
REQ-032: Rotate sweep: data=32'h0000_0001, num 0..31 from A -> rsp_data = 1 << ((32-num) mod 32) for each num, one result per cycle.
REQ-033: Counter wrap: 65536 A grants -> cnt_a returns to 0, cnt_b unchanged.
REQ-034: Assert rst while rsp_valid=1 and both requesters valid -> next cycle rsp_valid=0, counters 0, prio=0; after release A is granted first.
